// File: rtl/bcd_entry_controller_pkg.sv
// Shared definitions for the BCD digit entry controller.
// Holds the FSM state type and the default word size.
package bcd_entry_controller_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam int         DEF_NDIG = 4;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_entry_controller_if.sv
// Digit-in / word-out handshake bundle for the BCD entry controller.
// The controller is the slave; the digit source and word sink form the master.
interface bcd_entry_controller_if #(
  parameter int NDIG = 4
);
  localparam int CW = $clog2(NDIG + 1);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_digit;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_value;
  logic [CW-1:0]     out_count;
  logic              out_err;
  logic              out_ovf;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_value,
    input  out_count, out_err, out_ovf
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_value,
    output out_count, out_err, out_ovf
  );

endinterface

// File: rtl/bcd_entry_controller_digit_check.sv
// Flags a 4-bit code that is not a BCD digit (10..15).
// Purely combinational.
module bcd_digit_check (
  input  logic [3:0] d,
  output logic       bad
);

  assign bad = d[3] & (d[2] | d[1]);

endmodule

// File: rtl/bcd_entry_controller.sv
// Collects BCD digits into a packed word and hands it off via valid/ready.
// Invalid digits and digit overflow are flagged sticky per word.
module bcd_entry_controller
  import bcd_entry_controller_pkg::*;
#(
  parameter int NDIG = DEF_NDIG
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  bcd_entry_controller_if.slave bus
);

  localparam int CW = $clog2(NDIG + 1);

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic              bad;
  logic [4*NDIG+3:0] shifted;

  bcd_digit_check u_chk (
    .d   (bus.in_digit),
    .bad (bad)
  );

  // Oldest digit falls off the top when the word is already full.
  assign shifted = {value_q, bus.in_digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      value_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_COLLECT;
      value_d = '0;
      count_d = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (bus.in_valid) begin
            if (bad) begin
              err_d = 1'b1;
            end else begin
              value_d = shifted[4*NDIG-1:0];
              if (count_q == CW'(NDIG)) ovf_d = 1'b1;
              else count_d = count_q + CW'(1);
            end
            if (bus.in_last) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d = ST_COLLECT;
            value_d = '0;
            count_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_COLLECT);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_value = value_q;
  assign bus.out_count = count_q;
  assign bus.out_err   = err_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_entry_controller.sv
// Directed self-checking bench for bcd_entry_controller (NDIG=4).
// Inputs change #1 after posedge; outputs are sampled there too.
module tb_bcd_entry_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  bcd_entry_controller_if #(.NDIG(4)) bus ();

  bcd_entry_controller #(.NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_digit = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_digit  = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    tests++;
    if (bus.out_value !== 16'h0 || bus.out_count !== 3'd0 ||
        bus.out_err !== 1'b0 || bus.out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_fields got %h/%0d/%b/%b want 0000/0/0/0",
               bus.out_value, bus.out_count, bus.out_err, bus.out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early got vld=%b want 0", bus.out_valid);
    end
    send(4'd4, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_hs got vld=%b rdy=%b want 1 0",
               bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.out_value !== 16'h1234 || bus.out_count !== 3'd4 ||
        bus.out_err !== 1'b0 || bus.out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL basic_word got %h/%0d/%b/%b want 1234/4/0/0",
               bus.out_value, bus.out_count, bus.out_err, bus.out_ovf);
    end
    pop();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_value !== 16'h0 ||
        bus.out_count !== 3'd0) begin
      fails++;
      $display("FAIL basic_pop got vld=%b %h/%0d want 0 0000/0",
               bus.out_valid, bus.out_value, bus.out_count);
    end
  endtask

  task automatic test_err();
    send(4'd7, 1'b0);
    send(4'hB, 1'b0);
    send(4'd5, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 16'h0075 ||
        bus.out_count !== 3'd2 || bus.out_err !== 1'b1 ||
        bus.out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL err_word got v=%b %h/%0d/%b/%b want 1 0075/2/1/0",
               bus.out_valid, bus.out_value, bus.out_count,
               bus.out_err, bus.out_ovf);
    end
    pop();
  endtask

  task automatic test_ovf();
    for (int i = 1; i <= 5; i++) send(4'(i), 1'b0);
    send(4'd6, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 16'h3456 ||
        bus.out_count !== 3'd4 || bus.out_err !== 1'b0 ||
        bus.out_ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_word got v=%b %h/%0d/%b/%b want 1 3456/4/0/1",
               bus.out_valid, bus.out_value, bus.out_count,
               bus.out_err, bus.out_ovf);
    end
    pop();
  endtask

  task automatic test_empty();
    send(4'hE, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_count !== 3'd0 ||
        bus.out_err !== 1'b1 || bus.out_value !== 16'h0) begin
      fails++;
      $display("FAIL empty_word got v=%b %h/%0d/%b want 1 0000/0/1",
               bus.out_valid, bus.out_value, bus.out_count, bus.out_err);
    end
    pop();
  endtask

  task automatic test_hold_stall();
    send(4'd4, 1'b0);
    send(4'd2, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_digit = 4'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_value !== 16'h0042 || bus.out_count !== 3'd2 ||
          bus.out_err !== 1'b0 || bus.out_ovf !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d got r=%b v=%b %h/%0d want 0 1 0042/2",
                 i, bus.in_ready, bus.out_valid,
                 bus.out_value, bus.out_count);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_value !== 16'h0 || bus.out_count !== 3'd0) begin
      fails++;
      $display("FAIL stall_release got v=%b r=%b %h/%0d want 0 1 0000/0",
               bus.out_valid, bus.in_ready, bus.out_value, bus.out_count);
    end
    send(4'd3, 1'b1);
    tests++;
    if (bus.out_value !== 16'h0003 || bus.out_count !== 3'd1) begin
      fails++;
      $display("FAIL stall_next got %h/%0d want 0003/1",
               bus.out_value, bus.out_count);
    end
    pop();
  endtask

  task automatic test_clear();
    send(4'd8, 1'b0);
    send(4'd8, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (bus.out_value !== 16'h0 || bus.out_count !== 3'd0) begin
      fails++;
      $display("FAIL clear_mid got %h/%0d want 0000/0",
               bus.out_value, bus.out_count);
    end
    send(4'd2, 1'b1);
    tests++;
    if (bus.out_value !== 16'h0002 || bus.out_count !== 3'd1 ||
        bus.out_err !== 1'b0) begin
      fails++;
      $display("FAIL clear_word got %h/%0d/%b want 0002/1/0",
               bus.out_value, bus.out_count, bus.out_err);
    end
    pop();
    send(4'd6, 1'b1);
    clear = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clear = 1'b0;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 3'd0 ||
        bus.out_value !== 16'h0) begin
      fails++;
      $display("FAIL clear_hold got v=%b %h/%0d want 0 0000/0",
               bus.out_valid, bus.out_value, bus.out_count);
    end
    bus.in_valid = 1'b1;
    bus.in_digit = 4'd7;
    bus.in_last  = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 3'd0) begin
      fails++;
      $display("FAIL clear_drop got v=%b cnt=%0d want 0 0",
               bus.out_valid, bus.out_count);
    end
    send(4'd1, 1'b1);
    tests++;
    if (bus.out_value !== 16'h0001 || bus.out_count !== 3'd1) begin
      fails++;
      $display("FAIL clear_after got %h/%0d want 0001/1",
               bus.out_value, bus.out_count);
    end
    pop();
  endtask

  task automatic test_async_reset();
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_value !== 16'h0 || bus.out_count !== 3'd0 ||
        bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL arst_now got %h/%0d r=%b v=%b want 0000/0 1 0",
               bus.out_value, bus.out_count, bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(4'd9, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 16'h0009 ||
        bus.out_count !== 3'd1) begin
      fails++;
      $display("FAIL arst_next got v=%b %h/%0d want 1 0009/1",
               bus.out_valid, bus.out_value, bus.out_count);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_ovf();
    test_empty();
    test_hold_stall();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
